// File: rtl/pipe_reg_chain_pkg.sv
// Shared defaults and helpers for the pipe_reg_chain elastic register pipeline.
// Contents: default WIDTH/DEPTH and the occupancy-counter width function.
package pipe_reg_chain_pkg;

  localparam int unsigned PIPE_DEFAULT_WIDTH = 8;
  localparam int unsigned PIPE_DEFAULT_DEPTH = 2;

  // Bits needed to count 0..depth valid stages.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_chain_if.sv
// Handshake bundle for pipe_reg_chain.
// Signals: flush, in_valid/in_ready/in_data (upstream beat), out_valid/out_ready/out_data
// (downstream beat), occupancy (number of valid stages).
// master = the side feeding and draining the pipeline; slave = the pipeline itself.
interface pipe_reg_chain_if
  import pipe_reg_chain_pkg::*;
#(
  parameter int unsigned WIDTH = PIPE_DEFAULT_WIDTH,
  parameter int unsigned DEPTH = PIPE_DEFAULT_DEPTH
);

  localparam int unsigned CNT_W = occ_width(DEPTH);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] occupancy;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/pipe_reg_chain_stage.sv
// One pipeline stage: a valid bit plus a WIDTH-bit data register.
// Ports: clk, rst_n (sync, active low), clr (drop the held beat), adv (load from source),
// src_v/src_d (previous stage or upstream), v/d (held beat).
module pipe_reg_chain_stage
  import pipe_reg_chain_pkg::*;
#(
  parameter int unsigned WIDTH = PIPE_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic             src_v,
  input  logic [WIDTH-1:0] src_d,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  // Data only captures real beats so bubbles leave the last payload untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= 1'b0;
      d <= '0;
    end else begin
      if (clr) begin
        v <= 1'b0;
      end else if (adv) begin
        v <= src_v;
      end
      if (adv && src_v) begin
        d <= src_d;
      end
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic WIDTH x DEPTH register pipeline with valid/ready, bubble collapsing,
// flush and an occupancy count.
// Ports: clk, rst_n (sync, active low), bus (pipe_reg_chain_if.slave: flush,
// in_valid/in_ready/in_data, out_valid/out_ready/out_data, occupancy).
module pipe_reg_chain
  import pipe_reg_chain_pkg::*;
#(
  parameter int unsigned WIDTH = PIPE_DEFAULT_WIDTH,
  parameter int unsigned DEPTH = PIPE_DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_reg_chain_if.slave  bus
);

  localparam int unsigned CNT_W = occ_width(DEPTH);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d [DEPTH];
  logic [CNT_W-1:0] occ;
  logic             in_fire;
  logic             out_fire;

  // A stage advances if it or any stage downstream of it is empty, or the
  // output is being drained; the running OR avoids a self-referencing vector.
  always_comb begin
    logic run;
    run = bus.out_ready;
    adv = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      run    = run | ~v[k];
      adv[k] = run;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             src_v;
    logic [WIDTH-1:0] src_d;

    if (k == 0) begin : g_head
      assign src_v = bus.in_valid;
      assign src_d = bus.in_data;
    end else begin : g_body
      assign src_v = v[k-1];
      assign src_d = d[k-1];
    end

    pipe_reg_chain_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus.flush),
      .adv   (adv[k]),
      .src_v (src_v),
      .src_d (src_d),
      .v     (v[k]),
      .d     (d[k])
    );
  end

  // Stage 0 loads exactly when in_fire, since flush and reset override adv.
  assign bus.in_ready  = adv[0] & ~bus.flush & rst_n;
  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_data  = d[DEPTH-1];

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = v[DEPTH-1] & bus.out_ready;

  // Occupancy tracks popcount(v) incrementally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ <= '0;
    end else if (bus.flush) begin
      occ <= '0;
    end else if (in_fire && !out_fire) begin
      occ <= occ + CNT_W'(1);
    end else if (!in_fire && out_fire) begin
      occ <= occ - CNT_W'(1);
    end
  end

  assign bus.occupancy = occ;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain: directed scenarios on a DEPTH=3 build,
// mid-stream reset on DEPTH=1/3/4 builds, and a random valid/ready scoreboard.
module tb_pipe_reg_chain;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  int n_checks = 0;
  int n_errors = 0;

  pipe_reg_chain_if #(.WIDTH(8), .DEPTH(3)) bus3 ();
  pipe_reg_chain_if #(.WIDTH(8), .DEPTH(1)) bus1 ();
  pipe_reg_chain_if #(.WIDTH(8), .DEPTH(4)) bus4 ();

  assign bus3.flush     = flush;
  assign bus3.in_valid  = in_valid;
  assign bus3.in_data   = in_data;
  assign bus3.out_ready = out_ready;
  assign bus1.flush     = flush;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_data   = in_data;
  assign bus1.out_ready = out_ready;
  assign bus4.flush     = flush;
  assign bus4.in_valid  = in_valid;
  assign bus4.in_data   = in_data;
  assign bus4.out_ready = out_ready;

  pipe_reg_chain #(.WIDTH(8), .DEPTH(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));
  pipe_reg_chain #(.WIDTH(8), .DEPTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  pipe_reg_chain #(.WIDTH(8), .DEPTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0; flush = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_checks++; if (bus3.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid_d3: got %b expected 0", bus3.out_valid); end
    n_checks++; if (bus3.out_data !== 8'h00) begin n_errors++; $display("FAIL reset_out_data_d3: got %h expected 00", bus3.out_data); end
    n_checks++; if (bus3.occupancy !== 2'd0) begin n_errors++; $display("FAIL reset_occ_d3: got %0d expected 0", bus3.occupancy); end
    n_checks++; if (bus3.in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready_d3: got %b expected 0", bus3.in_ready); end
    n_checks++; if (bus1.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid_d1: got %b expected 0", bus1.out_valid); end
    n_checks++; if (bus1.in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready_d1: got %b expected 0", bus1.in_ready); end
    n_checks++; if (bus4.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid_d4: got %b expected 0", bus4.out_valid); end
    n_checks++; if (bus4.occupancy !== 3'd0) begin n_errors++; $display("FAIL reset_occ_d4: got %0d expected 0", bus4.occupancy); end
    next_cycle();
  endtask

  task automatic test_stream();
    int iv   [9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
    int id   [9] = '{1, 2, 3, 4, 5, 0, 0, 0, 0};
    int eov  [9] = '{0, 0, 0, 1, 1, 1, 1, 1, 0};
    int eod  [9] = '{0, 0, 0, 1, 2, 3, 4, 5, 0};
    int eocc [9] = '{0, 1, 2, 3, 3, 3, 2, 1, 0};
    rst_n = 1'b1; flush = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      in_valid = 1'(iv[c]); in_data = 8'(id[c]);
      @(negedge clk);
      n_checks++; if (bus3.in_ready !== 1'b1) begin n_errors++; $display("FAIL stream_in_ready c%0d: got %b expected 1", c, bus3.in_ready); end
      n_checks++; if (bus3.out_valid !== 1'(eov[c])) begin n_errors++; $display("FAIL stream_out_valid c%0d: got %b expected %0d", c, bus3.out_valid, eov[c]); end
      if (eov[c] != 0) begin
        n_checks++; if (bus3.out_data !== 8'(eod[c])) begin n_errors++; $display("FAIL stream_out_data c%0d: got %h expected %h", c, bus3.out_data, 8'(eod[c])); end
      end
      n_checks++; if (bus3.occupancy !== 2'(eocc[c])) begin n_errors++; $display("FAIL stream_occ c%0d: got %0d expected %0d", c, bus3.occupancy, eocc[c]); end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    int iv   [9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
    int id   [9] = '{'h10, 'h11, 'h12, 'h13, 'h13, 0, 0, 0, 0};
    int orr  [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
    int er   [9] = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
    int eov  [9] = '{0, 0, 0, 1, 1, 1, 1, 1, 0};
    int eod  [9] = '{0, 0, 0, 'h10, 'h10, 'h11, 'h12, 'h13, 0};
    int eocc [9] = '{0, 1, 2, 3, 3, 3, 2, 1, 0};
    rst_n = 1'b1; flush = 1'b0;
    for (int c = 0; c < 9; c++) begin
      in_valid = 1'(iv[c]); in_data = 8'(id[c]); out_ready = 1'(orr[c]);
      @(negedge clk);
      n_checks++; if (bus3.in_ready !== 1'(er[c])) begin n_errors++; $display("FAIL bp_in_ready c%0d: got %b expected %0d", c, bus3.in_ready, er[c]); end
      n_checks++; if (bus3.out_valid !== 1'(eov[c])) begin n_errors++; $display("FAIL bp_out_valid c%0d: got %b expected %0d", c, bus3.out_valid, eov[c]); end
      if (eov[c] != 0) begin
        n_checks++; if (bus3.out_data !== 8'(eod[c])) begin n_errors++; $display("FAIL bp_out_data c%0d: got %h expected %h", c, bus3.out_data, 8'(eod[c])); end
      end
      n_checks++; if (bus3.occupancy !== 2'(eocc[c])) begin n_errors++; $display("FAIL bp_occ c%0d: got %0d expected %0d", c, bus3.occupancy, eocc[c]); end
      next_cycle();
    end
  endtask

  task automatic test_bubble();
    int iv   [7] = '{1, 0, 0, 0, 0, 0, 0};
    int orr  [7] = '{0, 0, 0, 0, 0, 1, 1};
    int eov  [7] = '{0, 0, 0, 1, 1, 1, 0};
    int eocc [7] = '{0, 1, 1, 1, 1, 1, 0};
    rst_n = 1'b1; flush = 1'b0; in_data = 8'h7F;
    for (int c = 0; c < 7; c++) begin
      in_valid = 1'(iv[c]); out_ready = 1'(orr[c]);
      @(negedge clk);
      n_checks++; if (bus3.in_ready !== 1'b1) begin n_errors++; $display("FAIL bubble_in_ready c%0d: got %b expected 1", c, bus3.in_ready); end
      n_checks++; if (bus3.out_valid !== 1'(eov[c])) begin n_errors++; $display("FAIL bubble_out_valid c%0d: got %b expected %0d", c, bus3.out_valid, eov[c]); end
      if (eov[c] != 0) begin
        n_checks++; if (bus3.out_data !== 8'h7F) begin n_errors++; $display("FAIL bubble_out_data c%0d: got %h expected 7f", c, bus3.out_data); end
      end
      n_checks++; if (bus3.occupancy !== 2'(eocc[c])) begin n_errors++; $display("FAIL bubble_occ c%0d: got %0d expected %0d", c, bus3.occupancy, eocc[c]); end
      next_cycle();
    end
  endtask

  task automatic test_flush();
    int iv   [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    int id   [9] = '{'hA0, 'hA1, 'hA2, 'hEE, 0, 0, 0, 0, 0};
    int orr  [9] = '{0, 0, 0, 1, 1, 1, 1, 1, 1};
    int fl   [9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
    int er   [9] = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
    int eov  [9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
    int eocc [9] = '{0, 1, 2, 3, 0, 0, 0, 0, 0};
    rst_n = 1'b1;
    for (int c = 0; c < 9; c++) begin
      in_valid = 1'(iv[c]); in_data = 8'(id[c]); out_ready = 1'(orr[c]); flush = 1'(fl[c]);
      @(negedge clk);
      n_checks++; if (bus3.in_ready !== 1'(er[c])) begin n_errors++; $display("FAIL flush_in_ready c%0d: got %b expected %0d", c, bus3.in_ready, er[c]); end
      n_checks++; if (bus3.out_valid !== 1'(eov[c])) begin n_errors++; $display("FAIL flush_out_valid c%0d: got %b expected %0d", c, bus3.out_valid, eov[c]); end
      if (eov[c] != 0) begin
        n_checks++; if (bus3.out_data !== 8'hA0) begin n_errors++; $display("FAIL flush_out_data c%0d: got %h expected a0", c, bus3.out_data); end
      end
      n_checks++; if (bus3.occupancy !== 2'(eocc[c])) begin n_errors++; $display("FAIL flush_occ c%0d: got %0d expected %0d", c, bus3.occupancy, eocc[c]); end
      next_cycle();
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_midstream();
    rst_n = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hB0;
    next_cycle();
    in_data = 8'hB1;
    next_cycle();
    rst_n = 1'b0; in_data = 8'hB2;
    @(negedge clk);
    n_checks++; if (bus1.occupancy !== 1'd1) begin n_errors++; $display("FAIL midrst_pre_occ_d1: got %0d expected 1", bus1.occupancy); end
    n_checks++; if (bus3.occupancy !== 2'd2) begin n_errors++; $display("FAIL midrst_pre_occ_d3: got %0d expected 2", bus3.occupancy); end
    n_checks++; if (bus4.occupancy !== 3'd2) begin n_errors++; $display("FAIL midrst_pre_occ_d4: got %0d expected 2", bus4.occupancy); end
    n_checks++; if (bus1.in_ready !== 1'b0) begin n_errors++; $display("FAIL midrst_in_ready_d1: got %b expected 0", bus1.in_ready); end
    n_checks++; if (bus3.in_ready !== 1'b0) begin n_errors++; $display("FAIL midrst_in_ready_d3: got %b expected 0", bus3.in_ready); end
    n_checks++; if (bus4.in_ready !== 1'b0) begin n_errors++; $display("FAIL midrst_in_ready_d4: got %b expected 0", bus4.in_ready); end
    next_cycle();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++; if (bus1.out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_stale_d1 c%0d: got out_valid=%b data=%h expected 0", c, bus1.out_valid, bus1.out_data); end
      n_checks++; if (bus3.out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_stale_d3 c%0d: got out_valid=%b data=%h expected 0", c, bus3.out_valid, bus3.out_data); end
      n_checks++; if (bus4.out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_stale_d4 c%0d: got out_valid=%b data=%h expected 0", c, bus4.out_valid, bus4.out_data); end
      n_checks++; if (bus1.occupancy !== 1'd0) begin n_errors++; $display("FAIL midrst_occ_d1 c%0d: got %0d expected 0", c, bus1.occupancy); end
      n_checks++; if (bus3.occupancy !== 2'd0) begin n_errors++; $display("FAIL midrst_occ_d3 c%0d: got %0d expected 0", c, bus3.occupancy); end
      n_checks++; if (bus4.occupancy !== 3'd0) begin n_errors++; $display("FAIL midrst_occ_d4 c%0d: got %0d expected 0", c, bus4.occupancy); end
      next_cycle();
    end
  endtask

  task automatic test_random();
    logic [7:0] q1 [$];
    logic [7:0] q3 [$];
    logic [7:0] q4 [$];
    int acc3  = 0;
    int drain = 0;
    bit done  = 1'b0;
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 40000 && !done; cyc++) begin
      if (acc3 < 10000) begin
        in_valid  = ($urandom_range(3) != 0);
        in_data   = 8'($urandom);
        out_ready = ($urandom_range(3) != 0);
        flush     = ($urandom_range(63) == 0);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        drain++;
      end
      @(negedge clk);
      // DEPTH=3
      n_checks++; if (bus3.occupancy !== 2'(q3.size())) begin n_errors++; $display("FAIL rnd_occ_d3 cyc%0d: got %0d expected %0d", cyc, bus3.occupancy, q3.size()); end
      n_checks++; if (bus3.in_ready !== (!flush && (q3.size() < 3 || out_ready))) begin n_errors++; $display("FAIL rnd_in_ready_d3 cyc%0d: got %b expected %b", cyc, bus3.in_ready, (!flush && (q3.size() < 3 || out_ready))); end
      if (bus3.out_valid === 1'b1 && out_ready) begin
        n_checks++;
        if (q3.size() == 0) begin n_errors++; $display("FAIL rnd_extra_beat_d3 cyc%0d: got %h expected no beat", cyc, bus3.out_data); end
        else begin
          if (bus3.out_data !== q3[0]) begin n_errors++; $display("FAIL rnd_data_d3 cyc%0d: got %h expected %h", cyc, bus3.out_data, q3[0]); end
          void'(q3.pop_front());
        end
      end
      if (in_valid && bus3.in_ready === 1'b1) begin q3.push_back(in_data); acc3++; end
      if (flush) q3.delete();
      // DEPTH=1
      n_checks++; if (bus1.occupancy !== 1'(q1.size())) begin n_errors++; $display("FAIL rnd_occ_d1 cyc%0d: got %0d expected %0d", cyc, bus1.occupancy, q1.size()); end
      n_checks++; if (bus1.in_ready !== (!flush && (q1.size() < 1 || out_ready))) begin n_errors++; $display("FAIL rnd_in_ready_d1 cyc%0d: got %b expected %b", cyc, bus1.in_ready, (!flush && (q1.size() < 1 || out_ready))); end
      if (bus1.out_valid === 1'b1 && out_ready) begin
        n_checks++;
        if (q1.size() == 0) begin n_errors++; $display("FAIL rnd_extra_beat_d1 cyc%0d: got %h expected no beat", cyc, bus1.out_data); end
        else begin
          if (bus1.out_data !== q1[0]) begin n_errors++; $display("FAIL rnd_data_d1 cyc%0d: got %h expected %h", cyc, bus1.out_data, q1[0]); end
          void'(q1.pop_front());
        end
      end
      if (in_valid && bus1.in_ready === 1'b1) q1.push_back(in_data);
      if (flush) q1.delete();
      // DEPTH=4
      n_checks++; if (bus4.occupancy !== 3'(q4.size())) begin n_errors++; $display("FAIL rnd_occ_d4 cyc%0d: got %0d expected %0d", cyc, bus4.occupancy, q4.size()); end
      n_checks++; if (bus4.in_ready !== (!flush && (q4.size() < 4 || out_ready))) begin n_errors++; $display("FAIL rnd_in_ready_d4 cyc%0d: got %b expected %b", cyc, bus4.in_ready, (!flush && (q4.size() < 4 || out_ready))); end
      if (bus4.out_valid === 1'b1 && out_ready) begin
        n_checks++;
        if (q4.size() == 0) begin n_errors++; $display("FAIL rnd_extra_beat_d4 cyc%0d: got %h expected no beat", cyc, bus4.out_data); end
        else begin
          if (bus4.out_data !== q4[0]) begin n_errors++; $display("FAIL rnd_data_d4 cyc%0d: got %h expected %h", cyc, bus4.out_data, q4[0]); end
          void'(q4.pop_front());
        end
      end
      if (in_valid && bus4.in_ready === 1'b1) q4.push_back(in_data);
      if (flush) q4.delete();
      next_cycle();
      if (drain >= 6) done = 1'b1;
    end
    n_checks++; if (!done) begin n_errors++; $display("FAIL rnd_budget: got %0d beats expected 10000 within cycle budget", acc3); end
    n_checks++; if (q1.size() != 0) begin n_errors++; $display("FAIL rnd_lost_d1: got %0d undelivered beats expected 0", q1.size()); end
    n_checks++; if (q3.size() != 0) begin n_errors++; $display("FAIL rnd_lost_d3: got %0d undelivered beats expected 0", q3.size()); end
    n_checks++; if (q4.size() != 0) begin n_errors++; $display("FAIL rnd_lost_d4: got %0d undelivered beats expected 0", q4.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
